// File: rtl/median_wr_buf.sv
// median_wr_buf: packs four median pixels per group into a word, buffers it in a small FIFO
// and writes one frame of FRAME_WORDS words to memory at consecutive addresses.
module median_wr_buf #(
  parameter int PIXEL_DATA_WIDTH = 8,
  parameter int MEM_DATA_WIDTH   = 32,
  parameter int MEM_ADDR_WIDTH   = 10,
  parameter int FRAME_WORDS      = 1024,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel1,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel2,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel3,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_pixel4,
  output logic                        in_ready,
  input  logic                        mem_ready,
  output logic                        mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_waddr,
  output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0] FW = (MEM_ADDR_WIDTH+1)'(FRAME_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  r_state;
  logic [MEM_DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [AW:0]             r_wptr, r_rptr;
  logic [MEM_ADDR_WIDTH:0] r_acc, r_wcnt;
  logic                    w_empty, w_full, w_push, w_pop;
  assign w_empty  = r_wptr == r_rptr;
  assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign in_ready = (r_state == RUN) && !w_full && (r_acc < FW);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == RUN) && !w_empty && mem_ready;
  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= {in_pixel4, in_pixel3, in_pixel2, in_pixel1};
  // The frame ends the cycle after the last write is presented, so DONE follows the final mem_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_acc      <= '0;
      r_wcnt     <= '0;
      mem_we     <= 1'b0;
      mem_waddr  <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_we <= w_pop;
      if (w_pop) begin
        mem_wdata <= r_fifo[r_rptr[AW-1:0]];
        mem_waddr <= r_wcnt[MEM_ADDR_WIDTH-1:0];
        r_wcnt    <= r_wcnt + 1'b1;
        r_rptr    <= r_rptr + 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_acc  <= r_acc + 1'b1;
      end
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          busy    <= 1'b1;
          r_wptr  <= '0;
          r_rptr  <= '0;
          r_acc   <= '0;
          r_wcnt  <= '0;
        end
        RUN: if (r_wcnt == FW) begin
          r_state    <= DONE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          frame_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_median_wr_buf.sv
// tb_median_wr_buf: scoreboard bench; a 4-word-frame instance and a 1024-word-frame instance
// share the stimulus, and sel picks which one is being exercised and observed.
module tb_median_wr_buf;
  logic        clk = 0, rst_n = 0, start_s = 0, start_l = 0, in_valid = 0, mem_ready = 0, sel = 0;
  logic [7:0]  p1 = 0, p2 = 0, p3 = 0, p4 = 0;
  logic        ready_s, we_s, busy_s, done_s, ready_l, we_l, busy_l, done_l;
  logic [9:0]  waddr_s, waddr_l;
  logic [31:0] wdata_s, wdata_l;
  logic        in_ready, mem_we, busy, frame_done;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_wdata;
  int          n_cmp = 0, n_bad = 0;
  int          seq = 0, left = 0, cyc = 0, n_acc = 0, n_wr = 0, n_done = 0, mr_mode = 1;
  int          first_acc = -1, first_we = -1, last_we = 0, done_cyc = 0, max_occ = 0;
  int          a0, w0, d0;
  logic [9:0]  exp_addr = 0, last_addr = 0;
  logic [41:0] q[$];
  always #5 clk = ~clk;
  median_wr_buf #(.FRAME_WORDS(4)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid),
    .in_pixel1(p1), .in_pixel2(p2), .in_pixel3(p3), .in_pixel4(p4), .in_ready(ready_s),
    .mem_ready(mem_ready), .mem_we(we_s), .mem_waddr(waddr_s), .mem_wdata(wdata_s),
    .busy(busy_s), .frame_done(done_s));
  median_wr_buf u_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .in_valid(in_valid),
    .in_pixel1(p1), .in_pixel2(p2), .in_pixel3(p3), .in_pixel4(p4), .in_ready(ready_l),
    .mem_ready(mem_ready), .mem_we(we_l), .mem_waddr(waddr_l), .mem_wdata(wdata_l),
    .busy(busy_l), .frame_done(done_l));
  assign in_ready   = sel ? ready_l : ready_s;
  assign mem_we     = sel ? we_l : we_s;
  assign mem_waddr  = sel ? waddr_l : waddr_s;
  assign mem_wdata  = sel ? wdata_l : wdata_s;
  assign busy       = sel ? busy_l : busy_s;
  assign frame_done = sel ? done_l : done_s;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] grp(input int g);
    grp = {8'(4*g+4), 8'(4*g+3), 8'(4*g+2), 8'(4*g+1)};
  endfunction
  task automatic drive();
    in_valid = left > 0;
    {p4, p3, p2, p1} = grp(seq);
    mem_ready = (mr_mode == 2) ? ~mem_ready : (mr_mode == 1);
  endtask
  task automatic cycle();
    logic [41:0] e;
    logic acc;
    @(negedge clk);
    cyc++;
    if (mem_we) begin
      n_wr++;
      last_we = cyc;
      last_addr = mem_waddr;
      if (first_we < 0) first_we = cyc;
      if (q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        e = q.pop_front();
        chk("waddr", mem_waddr, e[41:32]);
        chk("wdata", mem_wdata, e[31:0]);
      end
    end
    if (q.size() > max_occ) max_occ = q.size();
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    acc = in_valid && in_ready;
    if (acc) begin
      q.push_back({exp_addr, p4, p3, p2, p1});
      exp_addr++;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      seq++;
      left--;
    end
    drive();
  endtask
  task automatic do_start(input bit fresh);
    if (fresh) exp_addr = 0;
    if (sel) start_l = 1; else start_s = 1;
    cycle();
    start_l = 0;
    start_s = 0;
  endtask
  task automatic offer(input int n);
    left += n;
    drive();
  endtask
  task automatic wait_done(input int budget);
    int d;
    bit seen;
    d = n_done;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      seen = n_done != d;
    end
    chk("frame_done_seen", seen, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_addr_data", {mem_waddr, mem_wdata}, 0);
    rst_n = 1;
    // idle input must not be accepted
    offer(1);
    repeat (3) cycle();
    chk("idle_ready", in_ready, 0);
    chk("idle_acc", n_acc, 0);
    // basic frame of 4 words on the small instance
    do_start(1);
    offer(3);
    wait_done(40);
    chk("basic_writes", n_wr, 4);
    chk("basic_last_addr", last_addr, 3);
    chk("basic_last_data", mem_wdata, grp(3));
    chk("basic_latency", first_we - first_acc, 2);
    chk("basic_done_delay", done_cyc - last_we, 1);
    cycle();
    chk("basic_idle_busy", busy, 0);
    chk("basic_done_pulse", n_done, 1);
    chk("basic_idle_ready", in_ready, 0);
    // backpressure on the large instance
    sel = 1;
    mr_mode = 0;
    drive();
    do_start(1);
    a0 = n_acc;
    w0 = n_wr;
    offer(6);
    repeat (10) cycle();
    chk("bp_accepts", n_acc - a0, 4);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_no_we", n_wr - w0, 0);
    do_start(0);
    chk("ign_start_busy", busy, 1);
    mr_mode = 1;
    drive();
    repeat (15) cycle();
    chk("bp_writes", n_wr - w0, 6);
    chk("bp_last_addr", last_addr, 5);
    chk("bp_busy", busy, 1);
    // simultaneous push/pop with toggling mem_ready
    mr_mode = 2;
    max_occ = 0;
    w0 = n_wr;
    offer(40);
    repeat (100) cycle();
    chk("pp_writes", n_wr - w0, 40);
    chk("pp_max_occ", max_occ, 4);
    chk("pp_q_empty", q.size(), 0);
    // reset with words buffered
    mr_mode = 0;
    drive();
    a0 = n_acc;
    offer(3);
    repeat (6) cycle();
    chk("rm_buffered", n_acc - a0, 3);
    rst_n = 0;
    #1;
    chk("rm_ready", in_ready, 0);
    chk("rm_we", mem_we, 0);
    chk("rm_busy", busy, 0);
    chk("rm_done", frame_done, 0);
    chk("rm_addr", mem_waddr, 0);
    chk("rm_data", mem_wdata, 0);
    q.delete();
    left = 0;
    mr_mode = 1;
    drive();
    repeat (2) cycle();
    rst_n = 1;
    w0 = n_wr;
    repeat (3) cycle();
    chk("rm_no_we", n_wr - w0, 0);
    do_start(1);
    offer(1);
    repeat (6) cycle();
    chk("rm_one_write", n_wr - w0, 1);
    chk("rm_first_addr", last_addr, 0);
    // rest of this 1024-word frame exercises the address wrap
    d0 = n_done;
    offer(1023);
    wait_done(1200);
    chk("wrap_writes", n_wr - w0, 1024);
    chk("wrap_last_addr", last_addr, 10'h3ff);
    cycle();
    chk("wrap_done_pulse", n_done - d0, 1);
    do_start(1);
    offer(1);
    repeat (5) cycle();
    chk("wrap_next_addr", last_addr, 0);
    chk("wrap_next_busy", busy, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/median_wr_buf.md
MEDIAN_WR_BUF -- requirements
Module: median_wr_buf

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- PIXEL_DATA_WIDTH, 8, width of each median pixel.
- MEM_DATA_WIDTH, 32, output memory word width; SHALL equal 4*PIXEL_DATA_WIDTH.
- MEM_ADDR_WIDTH, 10, output memory address width.
- FRAME_WORDS, 1024, words written per frame; range 1..2^MEM_ADDR_WIDTH.
- FIFO_DEPTH, 4, word buffer depth; power of two, at least 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a frame; sampled only in IDLE.
- in_valid, in, 1, median pixel group valid.
- in_pixel1..in_pixel4, in, PIXEL_DATA_WIDTH each, four median pixels from the median stage.
- in_ready, out, 1, block accepts the group this cycle.
- mem_ready, in, 1, output memory can take a write this cycle.
- mem_we, out, 1, write strobe (registered).
- mem_waddr, out, MEM_ADDR_WIDTH, write address (registered).
- mem_wdata, out, MEM_DATA_WIDTH, write data (registered).
- busy, out, 1, high in RUN.
- frame_done, out, 1, one-cycle pulse after the last write.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE. IDLE->RUN on start; RUN->DONE when FRAME_WORDS writes are issued; DONE->IDLE unconditionally after 1 cycle.
REQ-004 On IDLE->RUN, the accept counter, write address counter and FIFO SHALL clear to 0.
REQ-005 A transfer SHALL occur only when in_valid && in_ready. No input is ever dropped; the upstream holds data while in_ready=0.
REQ-006 in_ready SHALL be 1 only when state==RUN, the FIFO is not full, and accepted<FRAME_WORDS. There is no same-cycle full bypass.
REQ-007 The packed word SHALL be {in_pixel4,in_pixel3,in_pixel2,in_pixel1}, with pixel1 in bits [PIXEL_DATA_WIDTH-1:0].
REQ-008 Pop: when state==RUN, the FIFO is non-empty and mem_ready=1, the head SHALL pop. At that edge mem_we<=1, mem_wdata<=head and mem_waddr<=write counter; the write counter then increments.
REQ-009 When no pop occurs, mem_we SHALL be 0 the next cycle. mem_waddr and mem_wdata SHALL hold their last values.
REQ-010 Latency: a group accepted at edge k into an empty FIFO, with mem_ready=1, SHALL have mem_we high during the cycle after edge k+1.
REQ-011 A push and pop in the same cycle SHALL leave the occupancy unchanged. Order is strictly FIFO.
REQ-012 The write counter SHALL count 0..FRAME_WORDS-1. A final increment past 2^MEM_ADDR_WIDTH-1 wraps to 0, and this wrap is harmless.
REQ-013 The cycle after the edge issuing write number FRAME_WORDS, the FSM SHALL be in DONE. frame_done SHALL be 1 only in DONE.
REQ-014 busy SHALL equal (state==RUN).
REQ-015 start SHALL be ignored in RUN and DONE.
REQ-016 mem_ready=0 SHALL stall pops indefinitely without data loss. in_ready drops once the FIFO is full.

Reset
REQ-017 rst_n=0 SHALL immediately force: state IDLE; FIFO empty; all counters 0; in_ready, mem_we, busy and frame_done 0; mem_waddr and mem_wdata 0.
REQ-018 Reset mid-frame SHALL discard buffered words. No write is issued until the next start.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Basic: FRAME_WORDS=4, mem_ready=1, start, then pixels (01,02,03,04), (05,06,07,08), ... back-to-back. Required: mem_wdata=04030201 at addr 0, 08070605 at addr 1, through addr 3; first mem_we 2 cycles after the first accept; frame_done 1 cycle after the last mem_we; then IDLE.
- Backpressure: mem_ready=0 while 6 groups are offered. Required: in_ready falls after 4 accepts and no mem_we occurs. Then raise mem_ready: all 6 words are written in order at consecutive addresses.
- Simultaneous push/pop: continuous in_valid with mem_ready toggling every cycle. Required: occupancy stays at most FIFO_DEPTH; no loss or duplication; a scoreboard matches.
- Wrap: FRAME_WORDS=1024, MEM_ADDR_WIDTH=10. Required: last write at addr 3FF; frame_done pulses; next frame starts at addr 000.
- Reset mid-frame: assert rst_n=0 with 3 words buffered. Required: all outputs are 0 immediately. After release and a new start, the first write is at addr 0 carrying the first new group only.
- Ignored start and idle input: start pulses during RUN change nothing; in_valid in IDLE gives in_ready=0 and no accept.
